// File: rtl/tile_frame_config_loader.sv
// tile_frame_config_loader: per-tile config frame loader; writes local frames to BL/WL, forwards the rest.
// Ports:
//   prog_clk, pReset                      clock, async active-high reset
//   s_valid/s_ready/s_tile_id/s_wl_addr/s_data   upstream frame stream
//   m_valid/m_ready/m_tile_id/m_wl_addr/m_data   one-entry forward slice to the next tile
//   bl, wl                                bit lines and one-hot word lines
//   frame_cnt                             saturating count of completed local writes
//   addr_err                              sticky out-of-range local address flag
module tile_frame_config_loader #(
  parameter int DATA_W = 40,
  parameter int NUM_WL = 4,
  parameter int ADDR_W = 2,
  parameter int ID_W = 8,
  parameter int TILE_ID = 0,
  parameter int WL_PULSE = 2
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [ID_W-1:0]   s_tile_id,
  input  logic [ADDR_W-1:0] s_wl_addr,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ID_W-1:0]   m_tile_id,
  output logic [ADDR_W-1:0] m_wl_addr,
  output logic [DATA_W-1:0] m_data,
  output logic [DATA_W-1:0] bl,
  output logic [NUM_WL-1:0] wl,
  output logic [15:0]       frame_cnt,
  output logic              addr_err
);
  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;
  localparam int CW = $clog2(WL_PULSE + 1);
  state_t state, state_nxt;
  logic [DATA_W-1:0] bl_nxt;
  logic [NUM_WL-1:0] wl_nxt;
  logic [CW-1:0] pulse_cnt, pulse_cnt_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [15:0] frame_cnt_q;
  logic accept, bcast, local_hit, fwd_hit, addr_ok;
  assign bcast = &s_tile_id;
  assign local_hit = (s_tile_id == ID_W'(TILE_ID)) || bcast;
  assign fwd_hit = (s_tile_id != ID_W'(TILE_ID)) || bcast;
  assign addr_ok = int'(s_wl_addr) < NUM_WL;
  assign s_ready = (state == IDLE) && (!m_valid || m_ready) && !pReset;
  assign accept = s_valid && s_ready;
  assign frame_cnt = frame_cnt_q;
  always_comb begin
    state_nxt = state;
    bl_nxt = bl;
    wl_nxt = wl;
    pulse_cnt_nxt = pulse_cnt;
    addr_nxt = addr_q;
    case (state)
      IDLE: if (accept && local_hit && addr_ok) begin
        state_nxt = SETUP;
        bl_nxt = s_data;
        addr_nxt = s_wl_addr;
      end
      SETUP: begin
        state_nxt = PULSE;
        wl_nxt = NUM_WL'(1) << addr_q;
        pulse_cnt_nxt = CW'(WL_PULSE - 1);
      end
      PULSE: if (pulse_cnt == '0) begin
        state_nxt = HOLD;
        wl_nxt = '0;
      end else pulse_cnt_nxt = pulse_cnt - 1'b1;
      HOLD: begin
        state_nxt = IDLE;
        bl_nxt = '0;
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge prog_clk or posedge pReset)
    if (pReset) begin
      state <= IDLE;
      bl <= '0;
      wl <= '0;
      pulse_cnt <= '0;
      addr_q <= '0;
      m_valid <= 1'b0;
      m_tile_id <= '0;
      m_wl_addr <= '0;
      m_data <= '0;
      frame_cnt_q <= '0;
      addr_err <= 1'b0;
    end else begin
      state <= state_nxt;
      bl <= bl_nxt;
      wl <= wl_nxt;
      pulse_cnt <= pulse_cnt_nxt;
      addr_q <= addr_nxt;
      if (accept && fwd_hit) begin
        m_valid <= 1'b1;
        m_tile_id <= s_tile_id;
        m_wl_addr <= s_wl_addr;
        m_data <= s_data;
      end else if (m_ready) m_valid <= 1'b0;
      if (accept && local_hit && !addr_ok) addr_err <= 1'b1;
      if (state == HOLD && frame_cnt_q != 16'hFFFF) frame_cnt_q <= frame_cnt_q + 1'b1;
    end
endmodule

// File: tb/tb_tile_frame_config_loader.sv
// tb_tile_frame_config_loader: directed table plus corner-case sequences for tile_frame_config_loader.
module tb_tile_frame_config_loader;
  logic clk = 1'b0;
  logic rst;
  logic s_valid, s_ready, m_valid, m_ready, addr_err;
  logic [7:0] s_tile_id, m_tile_id;
  logic [1:0] s_wl_addr, m_wl_addr;
  logic [39:0] s_data, m_data, bl;
  logic [2:0] wl;
  logic [15:0] frame_cnt;
  int tests = 0;
  int fails = 0;
  typedef struct {
    logic v;
    logic [7:0] id;
    logic [1:0] a;
    logic [39:0] d;
    logic mr;
    logic rdy;
    logic mv;
    logic [7:0] mid;
    logic [1:0] ma;
    logic [39:0] md;
    logic [39:0] bl;
    logic [2:0] wl;
    logic [15:0] cnt;
    logic err;
  } vec_t;
  vec_t tbl[$];
  tile_frame_config_loader #(
    .DATA_W(40), .NUM_WL(3), .ADDR_W(2), .ID_W(8), .TILE_ID(0), .WL_PULSE(2)
  ) dut (
    .prog_clk(clk), .pReset(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_tile_id(s_tile_id), .s_wl_addr(s_wl_addr), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_tile_id(m_tile_id), .m_wl_addr(m_wl_addr), .m_data(m_data),
    .bl(bl), .wl(wl), .frame_cnt(frame_cnt), .addr_err(addr_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  initial begin
    int acc, pulses, gap, min_gap, len;
    logic prev_hi;
    // v id a d mr | rdy mv mid ma md bl wl cnt err
    tbl.push_back('{1'b1, 8'h00, 2'd2, 40'hA5A5A5A5A5, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0, 40'h0,  40'hA5A5A5A5A5, 3'b000, 16'd0, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 2'd0, 40'h0,          1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 40'h0,  40'hA5A5A5A5A5, 3'b100, 16'd0, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 2'd0, 40'h0,          1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 40'h0,  40'hA5A5A5A5A5, 3'b100, 16'd0, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 2'd0, 40'h0,          1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 40'h0,  40'hA5A5A5A5A5, 3'b000, 16'd0, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 2'd0, 40'h0,          1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 40'h0,  40'h0,          3'b000, 16'd1, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 2'd0, 40'h0,          1'b1, 1'b1, 1'b0, 8'h00, 2'd0, 40'h0,  40'h0,          3'b000, 16'd1, 1'b0});
    tbl.push_back('{1'b1, 8'h03, 2'd1, 40'h33,         1'b0, 1'b1, 1'b1, 8'h03, 2'd1, 40'h33, 40'h0,          3'b000, 16'd1, 1'b0});
    tbl.push_back('{1'b1, 8'h05, 2'd2, 40'h55,         1'b0, 1'b0, 1'b1, 8'h03, 2'd1, 40'h33, 40'h0,          3'b000, 16'd1, 1'b0});
    tbl.push_back('{1'b1, 8'h05, 2'd2, 40'h55,         1'b1, 1'b1, 1'b1, 8'h05, 2'd2, 40'h55, 40'h0,          3'b000, 16'd1, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 2'd0, 40'h0,          1'b1, 1'b1, 1'b0, 8'h05, 2'd2, 40'h55, 40'h0,          3'b000, 16'd1, 1'b0});
    tbl.push_back('{1'b1, 8'h07, 2'd0, 40'h77,         1'b1, 1'b1, 1'b1, 8'h07, 2'd0, 40'h77, 40'h0,          3'b000, 16'd1, 1'b0});
    tbl.push_back('{1'b1, 8'h09, 2'd1, 40'h99,         1'b1, 1'b1, 1'b1, 8'h09, 2'd1, 40'h99, 40'h0,          3'b000, 16'd1, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 2'd0, 40'h0,          1'b1, 1'b1, 1'b0, 8'h09, 2'd1, 40'h99, 40'h0,          3'b000, 16'd1, 1'b0});
    tbl.push_back('{1'b1, 8'hFF, 2'd1, 40'h01,         1'b1, 1'b1, 1'b1, 8'hFF, 2'd1, 40'h01, 40'h01,         3'b000, 16'd1, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 2'd0, 40'h0,          1'b1, 1'b0, 1'b0, 8'hFF, 2'd1, 40'h01, 40'h01,         3'b010, 16'd1, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 2'd0, 40'h0,          1'b1, 1'b0, 1'b0, 8'hFF, 2'd1, 40'h01, 40'h01,         3'b010, 16'd1, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 2'd0, 40'h0,          1'b1, 1'b0, 1'b0, 8'hFF, 2'd1, 40'h01, 40'h01,         3'b000, 16'd1, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 2'd0, 40'h0,          1'b1, 1'b0, 1'b0, 8'hFF, 2'd1, 40'h01, 40'h0,          3'b000, 16'd2, 1'b0});
    tbl.push_back('{1'b1, 8'h00, 2'd3, 40'hFFFF,       1'b1, 1'b1, 1'b0, 8'hFF, 2'd1, 40'h01, 40'h0,          3'b000, 16'd2, 1'b1});
    tbl.push_back('{1'b1, 8'h00, 2'd0, 40'h0123456789, 1'b1, 1'b1, 1'b0, 8'hFF, 2'd1, 40'h01, 40'h0123456789, 3'b000, 16'd2, 1'b1});
    tbl.push_back('{1'b0, 8'h00, 2'd0, 40'h0,          1'b1, 1'b0, 1'b0, 8'hFF, 2'd1, 40'h01, 40'h0123456789, 3'b001, 16'd2, 1'b1});
    tbl.push_back('{1'b0, 8'h00, 2'd0, 40'h0,          1'b1, 1'b0, 1'b0, 8'hFF, 2'd1, 40'h01, 40'h0123456789, 3'b001, 16'd2, 1'b1});
    tbl.push_back('{1'b0, 8'h00, 2'd0, 40'h0,          1'b1, 1'b0, 1'b0, 8'hFF, 2'd1, 40'h01, 40'h0123456789, 3'b000, 16'd2, 1'b1});
    tbl.push_back('{1'b0, 8'h00, 2'd0, 40'h0,          1'b1, 1'b0, 1'b0, 8'hFF, 2'd1, 40'h01, 40'h0,          3'b000, 16'd3, 1'b1});
    tbl.push_back('{1'b0, 8'h00, 2'd0, 40'h0,          1'b1, 1'b1, 1'b0, 8'hFF, 2'd1, 40'h01, 40'h0,          3'b000, 16'd3, 1'b1});
    tbl.push_back('{1'b1, 8'hFF, 2'd3, 40'hAB,         1'b1, 1'b1, 1'b1, 8'hFF, 2'd3, 40'hAB, 40'h0,          3'b000, 16'd3, 1'b1});
    tbl.push_back('{1'b0, 8'h00, 2'd0, 40'h0,          1'b1, 1'b1, 1'b0, 8'hFF, 2'd3, 40'hAB, 40'h0,          3'b000, 16'd3, 1'b1});
    rst = 1'b1;
    s_valid = 1'b0;
    s_tile_id = '0;
    s_wl_addr = '0;
    s_data = '0;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_ready", s_ready, 0);
    chk("rst_mvalid", m_valid, 0);
    chk("rst_bl", bl, 0);
    chk("rst_wl", wl, 0);
    chk("rst_cnt", frame_cnt, 0);
    chk("rst_err", addr_err, 0);
    chk("rst_mdata", m_data, 0);
    @(negedge clk);
    rst = 1'b0;
    foreach (tbl[i]) begin
      @(negedge clk);
      s_valid = tbl[i].v;
      s_tile_id = tbl[i].id;
      s_wl_addr = tbl[i].a;
      s_data = tbl[i].d;
      m_ready = tbl[i].mr;
      #1;
      chk($sformatf("v%0d_ready", i), s_ready, tbl[i].rdy);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_mvalid", i), m_valid, tbl[i].mv);
      chk($sformatf("v%0d_mtile", i), m_tile_id, tbl[i].mid);
      chk($sformatf("v%0d_maddr", i), m_wl_addr, tbl[i].ma);
      chk($sformatf("v%0d_mdata", i), m_data, tbl[i].md);
      chk($sformatf("v%0d_bl", i), bl, tbl[i].bl);
      chk($sformatf("v%0d_wl", i), wl, tbl[i].wl);
      chk($sformatf("v%0d_cnt", i), frame_cnt, tbl[i].cnt);
      chk($sformatf("v%0d_err", i), addr_err, tbl[i].err);
    end
    // reset while a broadcast write is mid-pulse with its forward copy stalled
    @(negedge clk);
    s_valid = 1'b1;
    s_tile_id = 8'hFF;
    s_wl_addr = 2'd1;
    s_data = 40'hDEAD;
    m_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("mr_mvalid", m_valid, 1);
    @(negedge clk);
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("mr_wl_pulse", wl, 3'b010);
    chk("mr_bl_pulse", bl, 40'hDEAD);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_wl", wl, 0);
    chk("mr_bl", bl, 0);
    chk("mr_mvalid_rst", m_valid, 0);
    chk("mr_ready", s_ready, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_ready = 1'b1;
    #1;
    chk("mr_cnt", frame_cnt, 0);
    chk("mr_err", addr_err, 0);
    chk("mr_ready_rel", s_ready, 1);
    chk("mr_mtile", m_tile_id, 0);
    // saturation with back-to-back local frames
    @(negedge clk);
    force dut.frame_cnt_q = 16'hFFFE;
    #1;
    release dut.frame_cnt_q;
    s_tile_id = 8'h00;
    s_wl_addr = 2'd2;
    s_data = 40'h5A;
    acc = 0;
    pulses = 0;
    gap = 0;
    min_gap = 1000;
    len = 0;
    prev_hi = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clk);
      s_valid = acc < 2;
      #1;
      if (s_valid && s_ready) acc++;
      @(posedge clk);
      #1;
      chk($sformatf("sat_onehot_c%0d", c), $countones(wl) <= 1, 1);
      if (wl != 0) begin
        if (!prev_hi) begin
          pulses++;
          if (pulses > 1 && gap < min_gap) min_gap = gap;
          len = 0;
        end
        len++;
        gap = 0;
      end else begin
        if (prev_hi) chk("sat_pulse_len", len, 2);
        gap++;
      end
      prev_hi = wl != 0;
    end
    chk("sat_accepts", acc, 2);
    chk("sat_pulses", pulses, 2);
    chk("sat_min_gap_ge3", min_gap >= 3, 1);
    chk("sat_cnt", frame_cnt, 16'hFFFF);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tile_frame_config_loader.md
Name: tile_frame_config_loader

Overview:
- Memory-bank configuration loader that sits at the edge of each tile, in the word-line/bit-line network.
- Accepts addressed configuration frames over a valid/ready stream.
- Frames addressed to this tile drive its BL/WL arrays with a timed write sequence.
- All other frames are forwarded through a one-entry register slice to the next tile in the chain.
- Successor to fixed bl/wl pass-through wiring: parametrised in BL width, WL count and pulse length, with sequencing, broadcast, error detection and write counting.

Parameters:
- DATA_W, 40, bits per frame; width of the BL bus.
- NUM_WL, 4, word lines in this tile; must be >= 2.
- ADDR_W, 2, WL address width; must satisfy 2**ADDR_W >= NUM_WL.
- ID_W, 8, tile-ID width.
- TILE_ID, 0, this tile's ID. Must not equal the all-ones broadcast ID.
- WL_PULSE, 2, cycles WL is held high per write; must be >= 1.

Ports:
- prog_clk  input  1  configuration clock; all state on the rising edge.
- pReset  input  1  asynchronous, active-high reset.
- s_valid  input  1  upstream frame valid.
- s_ready  output  1  upstream frame ready.
- s_tile_id  input  ID_W  destination tile; all-ones means broadcast.
- s_wl_addr  input  ADDR_W  target word line.
- s_data  input  DATA_W  BL data.
- m_valid  output  1  forwarded frame valid.
- m_ready  input  1  downstream ready.
- m_tile_id  output  ID_W  forwarded tile ID.
- m_wl_addr  output  ADDR_W  forwarded WL address.
- m_data  output  DATA_W  forwarded data.
- bl  output  DATA_W  bit lines to the configuration memories.
- wl  output  NUM_WL  word lines; one-hot or zero.
- frame_cnt  output  16  completed local writes, saturating.
- addr_err  output  1  sticky flag: a local frame had an out-of-range address.

Behaviour:
- Reset (asynchronous assertion, synchronous release): state=IDLE; bl=0; wl=0; m_valid=0; m_* data=0; frame_cnt=0; addr_err=0.
- s_ready is forced to 0 while pReset is high.
- Ready rule: s_ready = (state==IDLE) && (!m_valid || m_ready) && !pReset.
- Acceptance: a frame is accepted on a rising edge with s_valid && s_ready.
- Classification on acceptance:
  - local = (s_tile_id==TILE_ID) or broadcast.
  - forward = (s_tile_id!=TILE_ID) or broadcast.
  - A broadcast frame is both written locally and forwarded.
- Forward slice:
  - On acceptance of a forward frame: load m_* and set m_valid=1.
  - Otherwise, on m_valid && m_ready: clear m_valid.
  - A load and a drain in the same cycle are legal; the new frame replaces the old and m_valid stays 1.
  - m_* are stable while m_valid && !m_ready.
- Local write FSM:
  - IDLE: on a local accept with s_wl_addr < NUM_WL, go to SETUP and register bl <= s_data.
  - IDLE: on a local accept with s_wl_addr >= NUM_WL, set addr_err=1, stay IDLE, leave bl/wl unchanged. A broadcast frame is still forwarded.
  - SETUP (1 cycle): bl driven, wl=0. Next: PULSE; load wl = one-hot(addr) and pulse counter = WL_PULSE-1.
  - PULSE (WL_PULSE cycles): wl one-hot and bl held. Decrement the counter; at 0, go to HOLD and clear wl.
  - HOLD (1 cycle): wl=0, bl held. Next: IDLE; bl <= 0; frame_cnt++ unless it is 0xFFFF.
- Timing, with acceptance at edge 0:
  - bl is valid from edge 0.
  - wl is high from edge 1 to edge 1+WL_PULSE.
  - IDLE and s_ready return at edge 2+WL_PULSE.
  - Local-write throughput is one frame per WL_PULSE+3 cycles.
- Forward-only frames never leave IDLE. Throughput is one per cycle while m_ready=1.
- wl is never multi-hot. wl never changes in the same cycle as bl.
- addr_err clears only on reset.
- Reset asserted mid-write: wl and bl drop to 0 immediately (asynchronously). The partial write is not counted, and any pending forwarded frame is discarded.

Test Plan:
- Local write, TILE_ID=0, WL_PULSE=2: frame id=0, addr=2, data=0xA5A5A5A5A5 → bl=0xA5A5A5A5A5 from edge 0; wl=4'b0100 for exactly 2 cycles; s_ready=0 for 4 cycles; frame_cnt=1; m_valid stays 0.
- Forward with back-pressure: id=3 accepted while m_ready=0 → m_valid=1 and m_* hold id=3; a second id=5 frame sees s_ready=0; after m_ready=1, id=5 is accepted on the next cycle; wl/bl stay 0 throughout.
- Broadcast: id=0xFF, addr=1, data=0x1 → local write on wl[1] and m_valid=1 with identical m_* fields; frame_cnt=1.
- Address error with NUM_WL=3: id=0, addr=3 → addr_err=1; wl stays 0; frame_cnt unchanged; s_ready stays 1; a following valid frame writes normally.
- Reset mid-pulse: assert pReset during PULSE → wl=0, bl=0, m_valid=0 and s_ready=0 immediately with no clock edge; after release, frame_cnt=0 and addr_err=0.
- Saturation and back-to-back: preload 65535 writes (or force frame_cnt), then issue 2 local frames → frame_cnt stays 0xFFFF; successive wl pulses are separated by at least 3 idle cycles.
